upg_mem_arbiter: RTL and testbench
==================================

# upg_mem_arbiter

Sequencing and arbitration controller for the CPU's memory ports during UART program upload. It sits between the core's data-store path, the UART programmer's write stream, and the instruction ROM / data RAM write ports. It grants those ports to exactly one master at a time, and it holds the core in reset while a new image is loaded. After loading, it releases the core cleanly from PC 0.

## Interface
Parameters:
- ADDR_W, 14: word-address width of each memory.
- RELEASE_CYC, 4: number of cycles `cpu_rst` stays high after `upg_done`. Must be ≥1.

Ports:
- clk  in  1  CPU clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- upg_req  in  1  load request from the programmer or button. Level input; only a 0→1 edge is used.
- upg_wen  in  1  programmer write strobe, one word per high cycle.
- upg_adr  in  ADDR_W+1  bit[ADDR_W] selects the target: 0 = instruction ROM, 1 = data RAM. Lower bits are the word address.
- upg_dat  in  32  programmer write data.
- upg_done  in  1  programmer has finished the image.
- cpu_wen  in  1  core data-store strobe.
- cpu_adr  in  ADDR_W  core data word address.
- cpu_dat  in  32  core store data.
- ram_wen / ram_adr / ram_dat  out  1 / ADDR_W / 32  data RAM write port.
- rom_wen / rom_adr / rom_dat  out  1 / ADDR_W / 32  instruction ROM write port.
- cpu_hold  out  1  freezes the PC and suppresses register-file writes.
- cpu_rst  out  1  synchronous reset request to the core.
- upg_busy  out  1  high in every state except RUN.
- load_cnt  out  16  number of words accepted in the current or most recent load.
- checksum  out  32  only present with UPG_CHECKSUM_EN.

## Operation
- State machine states: RUN, DRAIN, LOAD, RELEASE. Reset state is RUN.
- RUN
  - The RAM port follows the core: `ram_wen=cpu_wen`, `ram_adr=cpu_adr`, `ram_dat=cpu_dat`.
  - `rom_wen=0`.
  - A rising edge on `upg_req` moves the FSM to DRAIN.
- DRAIN (exactly 1 cycle)
  - `cpu_hold=1`.
  - The core's in-flight store still passes to RAM in this cycle.
  - Next state is always LOAD. `upg_done` is ignored in this state.
- LOAD
  - `cpu_hold=1`, `cpu_rst=1`. Core writes are blocked.
  - When `upg_wen=1`, the word is routed to ROM or RAM according to `upg_adr[ADDR_W]`, and `load_cnt` increments.
  - `upg_done=1` moves the FSM to RELEASE. A write presented in that same cycle is still accepted.
- RELEASE
  - `cpu_hold=1`, `cpu_rst=1`. No memory writes occur.
  - A down-counter is loaded with RELEASE_CYC−1 and counts to 0. At 0 the FSM returns to RUN.
- Edge detection: `upg_req` is registered once per cycle, and edge = current & ~previous. A request held high triggers only one load. Edges seen outside RUN are ignored.
- Writes outside LOAD:
  - `upg_wen` outside LOAD is dropped and not counted.
  - `cpu_wen` during LOAD or RELEASE is dropped.
- load_cnt
  - Cleared to 0 on the DRAIN→LOAD transition.
  - Saturates at 0xFFFF.
  - Holds its value in RUN.
- Write-port data and address outputs are don't-care whenever the matching `wen` is 0. The bench checks them only when `wen=1`.

## Timing
- `state`, `load_cnt`, the edge register, the release counter, and `checksum` are flops.
- The memory-port muxes, `cpu_hold`, `cpu_rst` and `upg_busy` are combinational from state. They have zero-cycle latency from the inputs.
- Reset values:
  - State RUN, so `cpu_hold=0`, `cpu_rst=0`, `upg_busy=0`, `rom_wen=0`.
  - `ram_wen` follows `cpu_wen`.
  - `load_cnt=0`, `checksum=0`, edge register 0.
- Latency from an `upg_req` edge to the first cycle in which a programmer write is accepted: 2 cycles (edge cycle in RUN, then DRAIN, then LOAD).
- Latency from `upg_done` to RUN: RELEASE_CYC+1 cycles, with `cpu_rst` high throughout.
- If `rst` is asserted mid-load, the FSM returns to RUN immediately. The partial image stays in memory, and `load_cnt` is cleared.

## Configuration
- UPG_CHECKSUM_EN
  - Defined:
    - The `checksum` port and a 32-bit register exist.
    - The register is cleared on DRAIN→LOAD.
    - Each accepted programmer word is XORed into it (`checksum ^= upg_dat`).
    - The register holds its value otherwise.
  - Undefined: the port and register are omitted. All other behaviour is identical.

## Test plan
- Reset, then `cpu_wen=1`, `cpu_adr=0x0010`, `cpu_dat=0xDEADBEEF` → `ram_wen=1` with the same address and data, `rom_wen=0`, `upg_busy=0`.
- `upg_req` pulse → DRAIN for 1 cycle with `cpu_hold=1` and a core store still reaching RAM. Then LOAD with `cpu_rst=1`, and `cpu_wen=1` produces `ram_wen=0`.
- In LOAD, 3 writes: `upg_adr=0x0000`/`0x0001` with data 0x00000013, then `upg_adr=0x4002`, `upg_dat=0x12345678` → two ROM writes at 0 and 1, one RAM write at 2, `load_cnt=3`, `checksum=0x12345678`.
- `upg_done` together with `upg_wen` → that write is accepted (`load_cnt` +1), `cpu_rst` stays high for exactly 4 cycles, then RUN with `upg_busy=0`.
- `upg_req` held high through a whole load and `upg_wen` pulsed in RUN → no second load and `load_cnt` unchanged.
- `rst` asserted during LOAD after 5 words → next sampled cycle shows RUN, `load_cnt=0`, `cpu_rst=0`.

Source files
------------

// File: rtl/upg_mem_arbiter.sv
// Memory-port arbiter for UART program upload: holds the core in reset while the programmer
// owns the ROM/RAM write ports, then releases it. Optional checksum via `UPG_CHECKSUM_EN.
module upg_mem_arbiter #(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned RELEASE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upg_req,
  input  logic              upg_wen,
  input  logic [ADDR_W:0]   upg_adr,
  input  logic [31:0]       upg_dat,
  input  logic              upg_done,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [31:0]       cpu_dat,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [31:0]       ram_dat,
  output logic              rom_wen,
  output logic [ADDR_W-1:0] rom_adr,
  output logic [31:0]       rom_dat,
  output logic              cpu_hold,
  output logic              cpu_rst,
  output logic              upg_busy,
  output logic [15:0]       load_cnt
`ifdef UPG_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam int unsigned CntW = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;

  typedef enum logic [1:0] {StRun, StDrain, StLoad, StRelease} state_e;

  state_e            state_q, state_d;
  logic              upg_req_q;
  logic              req_edge;
  logic              upg_accept;
  logic [CntW-1:0]   rel_cnt_q, rel_cnt_d;
  logic [15:0]       load_cnt_q, load_cnt_d;

  assign req_edge   = upg_req & ~upg_req_q;
  assign upg_accept = (state_q == StLoad) & upg_wen;
  assign load_cnt   = load_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      upg_req_q  <= 1'b0;
      rel_cnt_q  <= '0;
      load_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      upg_req_q  <= upg_req;
      rel_cnt_q  <= rel_cnt_d;
      load_cnt_q <= load_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rel_cnt_d  = rel_cnt_q;
    load_cnt_d = load_cnt_q;
    unique case (state_q)
      StRun: begin
        if (req_edge) state_d = StDrain;
      end
      StDrain: begin
        state_d    = StLoad;
        load_cnt_d = '0;
      end
      StLoad: begin
        if (upg_accept && (load_cnt_q != 16'hFFFF)) load_cnt_d = load_cnt_q + 16'd1;
        // A write presented alongside upg_done is still accepted above.
        if (upg_done) begin
          state_d   = StRelease;
          rel_cnt_d = CntW'(RELEASE_CYC - 1);
        end
      end
      StRelease: begin
        if (rel_cnt_q == '0) state_d = StRun;
        else                 rel_cnt_d = rel_cnt_q - CntW'(1);
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    cpu_hold = (state_q != StRun);
    cpu_rst  = (state_q == StLoad) || (state_q == StRelease);
    upg_busy = (state_q != StRun);
    ram_wen  = 1'b0;
    ram_adr  = cpu_adr;
    ram_dat  = cpu_dat;
    rom_wen  = 1'b0;
    rom_adr  = upg_adr[ADDR_W-1:0];
    rom_dat  = upg_dat;
    unique case (state_q)
      StRun, StDrain: begin
        // The core's in-flight store still lands during the drain cycle.
        ram_wen = cpu_wen;
      end
      StLoad: begin
        if (upg_wen) begin
          if (upg_adr[ADDR_W]) begin
            ram_wen = 1'b1;
            ram_adr = upg_adr[ADDR_W-1:0];
            ram_dat = upg_dat;
          end else begin
            rom_wen = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

`ifdef UPG_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (state_q == StDrain) checksum_d = '0;
    else if (upg_accept)    checksum_d = checksum_q ^ upg_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) checksum_q <= '0;
    else     checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_upg_mem_arbiter.sv
// Scoreboard bench for upg_mem_arbiter: expected memory writes are queued as stimulus is driven
// and popped when the DUT asserts a write enable.
module tb_upg_mem_arbiter;

  localparam int AW      = 14;
  localparam int PhRun   = 0;
  localparam int PhDrain = 1;
  localparam int PhLoad  = 2;
  localparam int PhRel   = 3;

  typedef struct packed {
    logic          to_ram;
    logic [AW-1:0] adr;
    logic [31:0]   dat;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          upg_req, upg_wen, upg_done, cpu_wen;
  logic [AW:0]   upg_adr;
  logic [31:0]   upg_dat, cpu_dat;
  logic [AW-1:0] cpu_adr;
  logic          ram_wen, rom_wen, cpu_hold, cpu_rst, upg_busy;
  logic [AW-1:0] ram_adr, rom_adr;
  logic [31:0]   ram_dat, rom_dat;
  logic [15:0]   load_cnt;
`ifdef UPG_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  wr_t         exp_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] exp_cnt = '0;
  logic [31:0] exp_sum = '0;

  upg_mem_arbiter #(
    .ADDR_W      (AW),
    .RELEASE_CYC (4)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .upg_req  (upg_req),
    .upg_wen  (upg_wen),
    .upg_adr  (upg_adr),
    .upg_dat  (upg_dat),
    .upg_done (upg_done),
    .cpu_wen  (cpu_wen),
    .cpu_adr  (cpu_adr),
    .cpu_dat  (cpu_dat),
    .ram_wen  (ram_wen),
    .ram_adr  (ram_adr),
    .ram_dat  (ram_dat),
    .rom_wen  (rom_wen),
    .rom_adr  (rom_adr),
    .rom_dat  (rom_dat),
    .cpu_hold (cpu_hold),
    .cpu_rst  (cpu_rst),
    .upg_busy (upg_busy),
    .load_cnt (load_cnt)
`ifdef UPG_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp_v);
  endtask

  task automatic check_wr(input logic to_ram, input logic [AW-1:0] adr, input logic [31:0] dat);
    wr_t e;
    if (exp_q.size() == 0) begin
      check(to_ram ? "unexpected_ram_wr" : "unexpected_rom_wr", 32'(adr), 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check("wr_target", 32'(to_ram), 32'(e.to_ram));
      check("wr_adr", 32'(adr), 32'(e.adr));
      check("wr_dat", dat, e.dat);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_wen) check_wr(1'b1, ram_adr, ram_dat);
      if (rom_wen) check_wr(1'b0, rom_adr, rom_dat);
    end
  end

  // One cycle: drive inputs, queue expected writes for the phase the DUT should be in, check status.
  task automatic step(input int ph, input logic cw, input logic [AW-1:0] ca, input logic [31:0] cd,
                      input logic uw, input logic [AW:0] ua, input logic [31:0] ud,
                      input logic ureq, input logic udone);
    wr_t e;
    @(posedge clk);
    #1;
    cpu_wen = cw; cpu_adr = ca; cpu_dat = cd;
    upg_wen = uw; upg_adr = ua; upg_dat = ud;
    upg_req = ureq; upg_done = udone;
    if (cw && (ph == PhRun || ph == PhDrain)) begin
      e.to_ram = 1'b1; e.adr = ca; e.dat = cd;
      exp_q.push_back(e);
    end
    if (uw && ph == PhLoad) begin
      e.to_ram = ua[AW]; e.adr = ua[AW-1:0]; e.dat = ud;
      exp_q.push_back(e);
    end
    @(negedge clk);
    check("cpu_hold", 32'(cpu_hold), 32'(ph != PhRun));
    check("cpu_rst", 32'(cpu_rst), 32'(ph == PhLoad || ph == PhRel));
    check("upg_busy", 32'(upg_busy), 32'(ph != PhRun));
    check("load_cnt", 32'(load_cnt), 32'(exp_cnt));
`ifdef UPG_CHECKSUM_EN
    check("checksum", checksum, exp_sum);
`endif
    if (ph == PhDrain) begin
      exp_cnt = '0;
      exp_sum = '0;
    end else if (ph == PhLoad && uw) begin
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      exp_sum = exp_sum ^ ud;
    end
  endtask

  initial begin
    rst = 1'b1;
    upg_req = 0; upg_wen = 0; upg_done = 0; upg_adr = '0; upg_dat = '0;
    cpu_wen = 1; cpu_adr = 14'h0033; cpu_dat = 32'h0BAD_F00D;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd0);
    check("rst_upg_busy", 32'(upg_busy), 32'd0);
    check("rst_rom_wen", 32'(rom_wen), 32'd0);
    check("rst_ram_wen", 32'(ram_wen), 32'd1);
    check("rst_ram_adr", 32'(ram_adr), 32'h0033);
    check("rst_load_cnt", 32'(load_cnt), 32'd0);
`ifdef UPG_CHECKSUM_EN
    check("rst_checksum", checksum, 32'd0);
`endif
    @(posedge clk);
    #1;
    cpu_wen = 0;
    rst = 1'b0;

    // Core store passes straight through in RUN.
    step(PhRun, 1, 14'h0010, 32'hDEAD_BEEF, 0, '0, '0, 0, 0);
    // Request edge, then drain (core store lands, stray upg_wen/upg_done ignored).
    step(PhRun, 0, '0, '0, 0, '0, '0, 1, 0);
    step(PhDrain, 1, 14'h0020, 32'hCAFE_F00D, 1, 15'h0007, 32'h1111_1111, 1, 1);
    // LOAD blocks the core.
    step(PhLoad, 1, 14'h0021, 32'h5555_5555, 0, '0, '0, 1, 0);
    step(PhLoad, 0, '0, '0, 1, 15'h0000, 32'h0000_0013, 1, 0);
    step(PhLoad, 0, '0, '0, 1, 15'h0001, 32'h0000_0013, 1, 0);
    step(PhLoad, 0, '0, '0, 1, 15'h4002, 32'h1234_5678, 1, 0);
    step(PhLoad, 0, '0, '0, 0, '0, '0, 1, 0);
    // Last word with upg_done, then exactly four release cycles.
    step(PhLoad, 0, '0, '0, 1, 15'h0005, 32'hA5A5_A5A5, 1, 1);
    for (int i = 0; i < 4; i++) step(PhRel, 1, 14'h0040, 32'h7777_7777, 1, 15'h0009, 32'h9, 1, 0);
    // Held request does not retrigger; upg_wen in RUN is dropped.
    step(PhRun, 0, '0, '0, 1, 15'h0003, 32'hFFFF_0000, 1, 0);
    step(PhRun, 0, '0, '0, 0, '0, '0, 1, 0);
    step(PhRun, 0, '0, '0, 0, '0, '0, 0, 0);
    // Second load interrupted by reset after five words.
    step(PhRun, 0, '0, '0, 0, '0, '0, 1, 0);
    step(PhDrain, 0, '0, '0, 0, '0, '0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(PhLoad, 0, '0, '0, 1, {i[0], 14'(i + 8)}, 32'hA000_0000 + 32'(i), 1, 0);
    end
    step(PhLoad, 0, '0, '0, 0, '0, '0, 1, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    upg_req = 0;
    @(negedge clk);
    check("midrst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("midrst_cpu_rst", 32'(cpu_rst), 32'd0);
    check("midrst_upg_busy", 32'(upg_busy), 32'd0);
    check("midrst_load_cnt", 32'(load_cnt), 32'd0);
    exp_cnt = '0;
`ifdef UPG_CHECKSUM_EN
    exp_sum = '0;
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(PhRun, 1, 14'h0123, 32'h0F0F_0F0F, 0, '0, '0, 0, 0);
    step(PhRun, 0, '0, '0, 0, '0, '0, 0, 0);

    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
